// File: rtl/seven_seg_arbiter.sv
// Round-robin owner selection for the shared four-digit seven-segment display.
// Each owner keeps the display for at least DWELL_CYCLES clocks before it rotates.
module seven_seg_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  localparam int CNT_W       = $clog2(DWELL_CYCLES),
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [16*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [15:0]          dataOut,
  output logic [3:0]           digitDisplay,
  output logic [3:0]           digitPoint,
  output logic                 busy
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [15:0]        data_reg, data_next;
  logic [3:0]         disp_reg, disp_next;
  logic [3:0]         point_reg, point_next;
  logic               busy_reg, busy_next;

  logic [15:0]        req_word [NUM_REQ];
  logic [NUM_REQ-1:0] sel_onehot;
  logic [IDX_W-1:0]   sel_idx;
  logic               found;
  logic               expired;
  logic               others_pending;
  logic               do_load;
  int                 cand;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_word[gi]   = req_data[16*gi +: 16];
      assign sel_onehot[gi] = (sel_idx == IDX_W'(gi));
    end
  endgenerate

  // First pending requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_reg) + k) % NUM_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        found   = 1'b1;
        sel_idx = IDX_W'(cand);
      end
    end
  end

  assign expired        = (cnt_reg == CNT_W'(DWELL_CYCLES - 1));
  // ptr always sits just past the owner, so the owner is searched last.
  assign others_pending = |(req & ~grant_reg);

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    cnt_next   = cnt_reg;
    grant_next = grant_reg;
    data_next  = data_reg;
    disp_next  = disp_reg;
    point_next = point_reg;
    busy_next  = busy_reg;
    do_load    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (found) do_load = 1'b1;
      end
      HOLD: begin
        if (!expired) begin
          cnt_next = cnt_reg + CNT_W'(1);
          if (req[owner_reg]) data_next = req_word[owner_reg];
        end else if (others_pending) begin
          do_load = 1'b1;
        end else if (req[owner_reg]) begin
          data_next = req_word[owner_reg];
        end else begin
          state_next = IDLE;
          grant_next = '0;
          data_next  = 16'h0000;
          disp_next  = 4'b0000;
          point_next = 4'b0000;
          busy_next  = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    if (do_load) begin
      state_next = HOLD;
      owner_next = sel_idx;
      ptr_next   = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
      cnt_next   = '0;
      grant_next = sel_onehot;
      data_next  = req_word[sel_idx];
      disp_next  = 4'b1111;
      point_next = 4'(sel_onehot);
      busy_next  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      cnt_reg   <= '0;
      grant_reg <= '0;
      data_reg  <= 16'h0000;
      disp_reg  <= 4'b0000;
      point_reg <= 4'b0000;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
      data_reg  <= data_next;
      disp_reg  <= disp_next;
      point_reg <= point_next;
      busy_reg  <= busy_next;
    end
  end

  assign grant        = grant_reg;
  assign dataOut      = data_reg;
  assign digitDisplay = disp_reg;
  assign digitPoint   = point_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_seven_seg_arbiter.sv
// Bench for seven_seg_arbiter: owner/age model checked every cycle,
// directed scenarios pinned with hand-computed literals.
module tb_seven_seg_arbiter;
  localparam int N  = 4;
  localparam int DW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req = '0;
  logic [16*N-1:0] req_data = '0;
  logic [N-1:0]    grant;
  logic [15:0]     dataOut;
  logic [3:0]      digitDisplay;
  logic [3:0]      digitPoint;
  logic            busy;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  seven_seg_arbiter #(.NUM_REQ(N), .DWELL_CYCLES(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant), .dataOut(dataOut), .digitDisplay(digitDisplay),
    .digitPoint(digitPoint), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: who owns the display, how long it has held it, and the shown value.
  int          m_owner = -1;
  int          m_ptr = 0;
  int          m_age = 0;
  logic [15:0] m_data = 16'h0000;

  function automatic logic [15:0] word(int i);
    return req_data[16*i +: 16];
  endfunction

  function automatic logic [3:0] onehot4(int i);
    logic [3:0] v;
    v = 4'b0000;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(logic [N-1:0] r, int from);
    for (int k = 0; k < N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic model_grant(int i);
    m_owner = i;
    m_data  = word(i);
    m_ptr   = (i + 1) % N;
    m_age   = 0;
  endtask

  always @(posedge clk or posedge reset) begin : model
    int pick;
    if (reset) begin
      m_owner = -1;
      m_ptr   = 0;
      m_age   = 0;
      m_data  = 16'h0000;
    end else if (m_owner < 0) begin
      pick = rr_pick(req, m_ptr);
      if (pick >= 0) model_grant(pick);
    end else if (m_age < DW - 1) begin
      m_age++;
      if (req[m_owner]) m_data = word(m_owner);
    end else if ((req & ~onehot4(m_owner)) != 0) begin
      model_grant(rr_pick(req, m_ptr));
    end else if (req[m_owner]) begin
      m_data = word(m_owner);
    end else begin
      m_owner = -1;
      m_data  = 16'h0000;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cycle, act, exp);
    end
  endtask

  logic [N-1:0] last_grant = '0;
  always @(negedge clk) begin
    cycle++;
    chk("grant", 32'(grant), 32'(onehot4(m_owner)));
    chk("dataOut", 32'(dataOut), 32'(m_data));
    chk("digitDisplay", 32'(digitDisplay), (m_owner >= 0) ? 32'hF : 32'h0);
    chk("digitPoint", 32'(digitPoint), 32'(onehot4(m_owner)));
    chk("busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
    chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
    if (grant !== last_grant)
      $display("cycle %0d grant=%b dataOut=%h digitPoint=%b", cycle, grant, dataOut, digitPoint);
    last_grant = grant;
  end

  // Literal expectation checked against both the DUT and the model.
  task automatic expect_lit(string tag, logic [3:0] g, logic [15:0] d);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".dataOut"}, 32'(dataOut), 32'(d));
    chk({tag, ".digitDisplay"}, 32'(digitDisplay), (g != 0) ? 32'hF : 32'h0);
    chk({tag, ".digitPoint"}, 32'(digitPoint), 32'(g));
    chk({tag, ".busy"}, 32'(busy), (g != 0) ? 32'd1 : 32'd0);
    chk({tag, ".model_grant"}, 32'(onehot4(m_owner)), 32'(g));
    chk({tag, ".model_data"}, 32'(m_data), 32'(d));
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_word(int i, logic [15:0] v);
    req_data[16*i +: 16] = v;
  endtask

  initial begin
    set_word(0, 16'h1111);
    set_word(1, 16'h2222);
    set_word(2, 16'h3333);
    set_word(3, 16'h4444);
    #1 reset = 1'b1;
    req = 4'b1111;

    // 1: reset with all requests, then first grant to requester 0
    for (int k = 0; k < 3; k++) begin
      tick(1);
      expect_lit("t1_reset", 4'b0000, 16'h0000);
    end
    reset = 1'b0;
    tick(1);
    expect_lit("t1_first", 4'b0001, 16'h1111);
    req = 4'b0000;
    tick(5);
    expect_lit("t1_idle", 4'b0000, 16'h0000);

    // 2: single request from IDLE, live data tracking
    req = 4'b0010;
    set_word(1, 16'h00A5);
    tick(1);
    expect_lit("t2_grant", 4'b0010, 16'h00A5);
    set_word(1, 16'h00A6);
    tick(1);
    expect_lit("t2_track", 4'b0010, 16'h00A6);
    req = 4'b0000;
    tick(5);
    expect_lit("t2_idle", 4'b0000, 16'h0000);

    // move ptr back to 0 via a grant to requester 3
    req = 4'b1000;
    tick(1);
    expect_lit("t3_pre", 4'b1000, 16'h4444);
    req = 4'b0000;
    tick(5);
    expect_lit("t3_pre_idle", 4'b0000, 16'h0000);

    // 3: two requesters alternate every DW cycles with no gap
    set_word(0, 16'h0A0A);
    set_word(2, 16'h0C0C);
    req = 4'b0101;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      if (k <= 4 || k == 9) expect_lit("t3_rr0", 4'b0001, 16'h0A0A);
      else                  expect_lit("t3_rr2", 4'b0100, 16'h0C0C);
    end
    req = 4'b0000;
    tick(5);
    expect_lit("t3_idle", 4'b0000, 16'h0000);

    // 4: owner drops request, value freezes until dwell expiry
    set_word(0, 16'h1234);
    req = 4'b0001;
    tick(1);
    expect_lit("t4_grant", 4'b0001, 16'h1234);
    req = 4'b0000;
    set_word(0, 16'hBEEF);
    for (int k = 2; k <= 4; k++) begin
      tick(1);
      expect_lit("t4_freeze", 4'b0001, 16'h1234);
    end
    tick(1);
    expect_lit("t4_idle", 4'b0000, 16'h0000);

    // 5: lone owner held past dwell, then a newcomer takes over next edge
    set_word(2, 16'h5555);
    req = 4'b0100;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      expect_lit("t5_hold", 4'b0100, (k <= 5) ? 16'h5555 : 16'h6666);
      if (k == 5) set_word(2, 16'h6666);
    end
    set_word(3, 16'h3C3C);
    req = 4'b1100;
    tick(1);
    expect_lit("t5_handover", 4'b1000, 16'h3C3C);
    req = 4'b0000;
    tick(5);
    expect_lit("t5_idle", 4'b0000, 16'h0000);

    // 6: async reset mid-HOLD while ptr=3, then ptr must restart at 0
    req = 4'b0100;
    tick(1);
    expect_lit("t6_grant", 4'b0100, 16'h6666);
    tick(1);
    #2 reset = 1'b1;
    #1 expect_lit("t6_async", 4'b0000, 16'h0000);
    req = 4'b1001;
    tick(2);
    expect_lit("t6_held", 4'b0000, 16'h0000);
    reset = 1'b0;
    tick(1);
    expect_lit("t6_ptr0", 4'b0001, 16'hBEEF);
    req = 4'b0000;
    tick(6);
    expect_lit("t6_idle", 4'b0000, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
